simps_ctrl_seq: RTL and testbench

Parametrised top-level control sequencer for the SIMPS board. It walks the reset → UFM program → UFM read-back → apply → inactive/active sequence. Per-state watchdog timeouts lead to a FAULT state. It also owns a bank of NUM_OVR clocked front-end override channels, which replace the old level-sensitive override latches. It sits between the debounced switch/sub-block status signals and the enable/relay/LED outputs in the top level.

---
 rtl/simps_ctrl_pkg.sv | 30 +++
 rtl/ovr_bank.sv | 46 ++++
 rtl/simps_ctrl_seq.sv | 137 +++++++++++++
 tb/tb_simps_ctrl_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simps_ctrl_pkg.sv
// Shared types and status codes for the SIMPS control sequencer.
package simps_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST_WAIT   = 4'd0,
    ST_RST_UFM    = 4'd1,
    ST_RST_CFG    = 4'd2,
    ST_PROG_WR    = 4'd3,
    ST_PROG_RD    = 4'd4,
    ST_PROG_APPLY = 4'd5,
    ST_INACTIVE   = 4'd6,
    ST_ACTIVE     = 4'd7,
    ST_FAULT      = 4'd8
  } ctrl_state_t;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_BLINK = 2'b01;
  localparam logic [1:0] LED_ON    = 2'b10;
  localparam logic [1:0] LED_FAST  = 2'b11;

  localparam logic [3:0] PSPOT_RST_DONE = 4'h3;
  localparam logic [3:0] PSPOT_CFG_DONE = 4'h6;
  localparam logic [3:0] PSPOT_APPLIED  = 4'h8;
  localparam logic [3:0] SG_RST_DONE    = 4'h3;
  localparam logic [3:0] SG_RUN         = 4'hA;
  localparam logic [3:0] SG_STOPPED     = 4'hD;
  localparam logic [3:0] CSR_DONE       = 4'hC;
  localparam logic [1:0] UFMW_DONE      = 2'd3;

endpackage

// File: rtl/ovr_bank.sv
// Clocked front-end override channels with output mux and enable gating.
// fsm_val/active_nxt/fault_nxt describe the cycle being entered, so chan_out lines up with controlstate.
module ovr_bank #(
  parameter int               NUM_OVR   = 5,
  parameter logic [NUM_OVR-1:0] GATE_MASK = 'b00011
) (
  input  logic               CLK_25M,
  input  logic               reset,
  input  logic [NUM_OVR-1:0] ovr_req,
  input  logic [NUM_OVR-1:0] ovr_val,
  input  logic [NUM_OVR-1:0] fsm_val,
  input  logic               active_nxt,
  input  logic               fault_nxt,
  output logic [NUM_OVR-1:0] ovr_active,
  output logic [NUM_OVR-1:0] chan_out
);

  logic [NUM_OVR-1:0] cap_q;
  logic [NUM_OVR-1:0] cap_nxt;
  logic [NUM_OVR-1:0] act_nxt;
  logic [NUM_OVR-1:0] out_nxt;

  always_comb begin
    act_nxt = ovr_active | ovr_req;
    cap_nxt = (cap_q & ~ovr_req) | (ovr_val & ovr_req);
    out_nxt = (act_nxt & cap_nxt) | (~act_nxt & fsm_val);
    // Overridden enables may only assert while ACTIVE; FAULT kills them unconditionally.
    out_nxt = out_nxt & ~(GATE_MASK & act_nxt & {NUM_OVR{~active_nxt}});
    out_nxt = out_nxt & ~(GATE_MASK & {NUM_OVR{fault_nxt}});
  end

  always_ff @(posedge CLK_25M) begin
    cap_q <= cap_nxt;
  end

  always_ff @(posedge CLK_25M) begin
    if (reset) begin
      ovr_active <= '0;
      chan_out   <= '0;
    end else begin
      ovr_active <= act_nxt;
      chan_out   <= out_nxt;
    end
  end

endmodule

// File: rtl/simps_ctrl_seq.sv
// SIMPS top-level control sequencer: reset/UFM program/apply/run FSM with per-state watchdog.
// Optional CTRL_STATUS_TX_EN adds a state-change event strobe for the status transmitter.
module simps_ctrl_seq
  import simps_ctrl_pkg::*;
#(
  parameter int                 NUM_OVR    = 5,
  parameter logic [NUM_OVR-1:0] GATE_MASK  = 'b00011,
  parameter int                 RESET_HOLD = 3,
  parameter int                 RD_WORDS   = 6,
  parameter int                 TIMEOUT    = 25_000_000
) (
  input  logic               CLK_25M,
  input  logic               reset,
  input  logic               sw_res,
  input  logic               sw_ena,
  input  logic               ena_rise,
  input  logic [3:0]         pspot_state,
  input  logic [3:0]         sgclk_state,
  input  logic [3:0]         csr_state,
  input  logic [1:0]         write_state,
  input  logic [7:0]         read_count,
  input  logic [NUM_OVR-1:0] fsm_chan,
  input  logic [NUM_OVR-1:0] ovr_req,
  input  logic [NUM_OVR-1:0] ovr_val,
  output logic [3:0]         controlstate,
  output logic               ufm_reset_n,
  output logic [1:0]         prog_led_mode,
  output logic               fault,
  output logic [NUM_OVR-1:0] ovr_active,
  output logic [NUM_OVR-1:0] chan_out
`ifdef CTRL_STATUS_TX_EN
  ,
  output logic               state_evt,
  output logic [3:0]         state_code
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  ctrl_state_t        state, state_nxt, tgt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic               go, wd_run, hold_done;
  logic               ch1_q, ch1_nxt;
  logic [1:0]         led_nxt;
  logic [NUM_OVR-1:0] fsm_val;

  always_comb begin
    go        = 1'b0;
    tgt       = state;
    hold_done = timer >= TMR_W'(RESET_HOLD);
    wd_run    = (state >= ST_RST_UFM) && (state <= ST_PROG_APPLY);
    case (state)
      ST_RST_WAIT:   if (ena_rise && sw_res) begin go = 1'b1; tgt = ST_RST_UFM; end
      ST_RST_UFM:    if (pspot_state == PSPOT_RST_DONE && sgclk_state == SG_RST_DONE && hold_done)
                       begin go = 1'b1; tgt = ST_RST_CFG; end
      ST_RST_CFG:    if (csr_state == CSR_DONE && pspot_state == PSPOT_CFG_DONE)
                       begin go = 1'b1; tgt = ST_PROG_WR; end
      ST_PROG_WR:    if (write_state == UFMW_DONE) begin go = 1'b1; tgt = ST_PROG_RD; end
      ST_PROG_RD:    if (read_count >= 8'(RD_WORDS)) begin go = 1'b1; tgt = ST_PROG_APPLY; end
      ST_PROG_APPLY: if (pspot_state == PSPOT_APPLIED && sgclk_state == SG_RUN && !sw_res && !sw_ena)
                       begin go = 1'b1; tgt = ST_INACTIVE; end
      ST_INACTIVE:   if (sgclk_state == SG_STOPPED && !sw_res && ena_rise)
                       begin go = 1'b1; tgt = ST_ACTIVE; end
      ST_ACTIVE:     if (sgclk_state == SG_RUN && !sw_res && !sw_ena)
                       begin go = 1'b1; tgt = ST_PROG_RD; end
      default: ;
    endcase

    // A real transition beats a watchdog expiry in the same cycle.
    if (go)                                         state_nxt = tgt;
    else if (wd_run && timer == TMR_W'(TIMEOUT - 1)) state_nxt = ST_FAULT;
    else                                            state_nxt = state;

    if (state_nxt != state || !wd_run) timer_nxt = '0;
    else                               timer_nxt = timer + 1'b1;

    led_nxt = prog_led_mode;
    if (state_nxt == ST_FAULT)                                    led_nxt = LED_FAST;
    else if (state_nxt == ST_RST_WAIT || state_nxt == ST_PROG_WR) led_nxt = LED_BLINK;
    else if (state == ST_PROG_WR && state_nxt == ST_PROG_RD)      led_nxt = LED_ON;

    ch1_nxt    = (state == ST_ACTIVE) && (state_nxt == ST_ACTIVE) &&
                 (ch1_q || (sgclk_state == SG_RUN && sw_ena));
    fsm_val    = fsm_chan;
    fsm_val[0] = (state_nxt == ST_ACTIVE);
    fsm_val[1] = ch1_nxt;
  end

  // State register, watchdog and registered status outputs
  always_ff @(posedge CLK_25M) begin
    if (reset) begin
      state         <= ST_RST_WAIT;
      timer         <= '0;
      ufm_reset_n   <= 1'b1;
      prog_led_mode <= LED_OFF;
      fault         <= 1'b0;
      ch1_q         <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      ufm_reset_n   <= !(state_nxt == ST_RST_UFM && timer_nxt < TMR_W'(RESET_HOLD));
      prog_led_mode <= led_nxt;
      fault         <= (state_nxt == ST_FAULT);
      ch1_q         <= ch1_nxt;
    end
  end

  assign controlstate = state;

`ifdef CTRL_STATUS_TX_EN
  always_ff @(posedge CLK_25M) begin
    if (reset) begin
      state_evt  <= (state != ST_RST_WAIT);
      state_code <= ST_RST_WAIT;
    end else begin
      state_evt  <= (state_nxt != state);
      state_code <= state_nxt;
    end
  end
`endif

  ovr_bank #(
    .NUM_OVR  (NUM_OVR),
    .GATE_MASK(GATE_MASK)
  ) u_ovr_bank (
    .CLK_25M   (CLK_25M),
    .reset     (reset),
    .ovr_req   (ovr_req),
    .ovr_val   (ovr_val),
    .fsm_val   (fsm_val),
    .active_nxt(state_nxt == ST_ACTIVE),
    .fault_nxt (state_nxt == ST_FAULT),
    .ovr_active(ovr_active),
    .chan_out  (chan_out)
  );

endmodule

// File: tb/tb_simps_ctrl_seq.sv
// Scoreboard bench for simps_ctrl_seq (short watchdog); checks CTRL_STATUS_TX_EN outputs when defined.
module tb_simps_ctrl_seq;
  import simps_ctrl_pkg::*;

  localparam int NUM_OVR    = 5;
  localparam int RESET_HOLD = 3;
  localparam int RD_WORDS   = 6;
  localparam int TIMEOUT    = 64;

  logic               CLK_25M = 1'b0;
  logic               reset;
  logic               sw_res, sw_ena, ena_rise;
  logic [3:0]         pspot_state, sgclk_state, csr_state;
  logic [1:0]         write_state;
  logic [7:0]         read_count;
  logic [NUM_OVR-1:0] fsm_chan, ovr_req, ovr_val;
  logic [3:0]         controlstate;
  logic               ufm_reset_n, fault;
  logic [1:0]         prog_led_mode;
  logic [NUM_OVR-1:0] ovr_active, chan_out;
`ifdef CTRL_STATUS_TX_EN
  logic               state_evt;
  logic [3:0]         state_code;
`endif

  simps_ctrl_seq #(
    .NUM_OVR(NUM_OVR), .GATE_MASK(5'b00011), .RESET_HOLD(RESET_HOLD),
    .RD_WORDS(RD_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_25M(CLK_25M), .reset(reset), .sw_res(sw_res), .sw_ena(sw_ena), .ena_rise(ena_rise),
    .pspot_state(pspot_state), .sgclk_state(sgclk_state), .csr_state(csr_state),
    .write_state(write_state), .read_count(read_count), .fsm_chan(fsm_chan),
    .ovr_req(ovr_req), .ovr_val(ovr_val), .controlstate(controlstate),
    .ufm_reset_n(ufm_reset_n), .prog_led_mode(prog_led_mode), .fault(fault),
    .ovr_active(ovr_active), .chan_out(chan_out)
`ifdef CTRL_STATUS_TX_EN
    , .state_evt(state_evt), .state_code(state_code)
`endif
  );

  always #20 CLK_25M = ~CLK_25M;

  typedef enum int {F_STATE, F_LED, F_URN, F_FAULT, F_CHAN, F_OVR} fld_t;
  typedef struct {
    string       tag;
    fld_t        fld;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   prev_exp = -1;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned observe(input fld_t f);
    case (f)
      F_STATE: return 32'(controlstate);
      F_LED:   return 32'(prog_led_mode);
      F_URN:   return 32'(ufm_reset_n);
      F_FAULT: return 32'(fault);
      F_CHAN:  return 32'(chan_out);
      default: return 32'(ovr_active);
    endcase
  endfunction

  task automatic expect_val(input string tag, input fld_t f, input int unsigned v);
    exp_t e;
    e.tag = tag; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  // One clock: every queued expectation must hold one cycle after its stimulus.
  task automatic tick(input string tag, input int exp_state);
    exp_t e;
    expect_val({tag, "_state"}, F_STATE, exp_state);
    @(posedge CLK_25M);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.fld), e.val);
    end
`ifdef CTRL_STATUS_TX_EN
    if (prev_exp >= 0) begin
      chk({tag, "_evt"}, 32'(state_evt), 32'(exp_state != prev_exp));
      if (exp_state != prev_exp) chk({tag, "_code"}, 32'(state_code), exp_state);
    end
`endif
    prev_exp = exp_state;
  endtask

  task automatic clear_inputs();
    sw_res = 0; sw_ena = 0; ena_rise = 0;
    pspot_state = 0; sgclk_state = 0; csr_state = 0;
    write_state = 0; read_count = 0; fsm_chan = 0; ovr_req = 0; ovr_val = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick("rst", 0);
    reset = 0;
  endtask

  task automatic go_state2();
    do_reset();
    ena_rise = 1; sw_res = 1; pspot_state = PSPOT_RST_DONE; sgclk_state = SG_RST_DONE;
    tick("g2_enter1", 1);
    ena_rise = 0;
    for (int i = 0; i < RESET_HOLD; i++) tick("g2_hold", 1);
    tick("g2_enter2", 2);
  endtask

  task automatic go_state6();
    go_state2();
    csr_state = CSR_DONE; pspot_state = PSPOT_CFG_DONE;
    tick("g6_s3", 3);
    write_state = UFMW_DONE;
    tick("g6_s4", 4);
    read_count = 8'(RD_WORDS);
    tick("g6_s5", 5);
    pspot_state = PSPOT_APPLIED; sgclk_state = SG_RUN; sw_res = 0; sw_ena = 0;
    tick("g6_s6", 6);
    read_count = 0; write_state = 0; csr_state = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb timeout");
  end

  initial begin
    clear_inputs();
    reset = 1;
    // Reset values
    expect_val("rst_led", F_LED, LED_OFF);
    expect_val("rst_urn", F_URN, 1);
    expect_val("rst_fault", F_FAULT, 0);
    expect_val("rst_chan", F_CHAN, 0);
    expect_val("rst_ovr", F_OVR, 0);
    tick("rst0", 0);
    reset = 0;
    expect_val("wait_led", F_LED, LED_BLINK);
    tick("wait", 0);

    // Nominal sequence 0 -> 6
    ena_rise = 1; sw_res = 1;
    expect_val("ufm_urn0", F_URN, 0);
    tick("ufm_entry", 1);
    ena_rise = 0; pspot_state = PSPOT_RST_DONE; sgclk_state = SG_RST_DONE;
    expect_val("ufm_urn1", F_URN, 0);
    tick("ufm_h1", 1);
    expect_val("ufm_urn2", F_URN, 0);
    tick("ufm_h2", 1);
    expect_val("ufm_urn3", F_URN, 1);
    tick("ufm_h3", 1);
    expect_val("cfg_urn", F_URN, 1);
    tick("cfg", 2);
    csr_state = CSR_DONE; pspot_state = PSPOT_CFG_DONE;
    expect_val("wr_led", F_LED, LED_BLINK);
    tick("wr", 3);
    write_state = UFMW_DONE;
    expect_val("rd_led", F_LED, LED_ON);
    tick("rd", 4);
    read_count = 8'(RD_WORDS);
    tick("apply", 5);
    pspot_state = PSPOT_APPLIED; sgclk_state = SG_RUN; sw_res = 0; sw_ena = 0;
    expect_val("inact_chan", F_CHAN, 0);
    tick("inact", 6);
    read_count = 0;
    tick("inact_hold", 6);

    // Active cycle
    sgclk_state = SG_STOPPED; ena_rise = 1;
    expect_val("act_ch0", F_CHAN, 5'b00001);
    tick("act", 7);
    ena_rise = 0; sgclk_state = SG_RUN; sw_ena = 1;
    expect_val("act_ch1", F_CHAN, 5'b00011);
    tick("act_run", 7);
    sw_ena = 0;
    expect_val("act_exit_chan", F_CHAN, 0);
    expect_val("act_exit_led", F_LED, LED_ON);
    tick("act_exit", 4);

    // Watchdog timeout in RST_CFG
    go_state2();
    csr_state = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick("to_wait", 2);
    expect_val("to_fault", F_FAULT, 1);
    expect_val("to_led", F_LED, LED_FAST);
    expect_val("to_chan", F_CHAN, 0);
    tick("to", 8);
    ovr_req = 5'b00111; ovr_val = 5'b00111;
    expect_val("flt_ovr_chan", F_CHAN, 5'b00100);
    expect_val("flt_ovr_act", F_OVR, 5'b00111);
    tick("flt_ovr", 8);
    ovr_req = 0;
    tick("flt_stay", 8);
    reset = 1; ovr_req = 5'b11111; ovr_val = 5'b11111;
    expect_val("rstovr_act", F_OVR, 0);
    expect_val("rstovr_chan", F_CHAN, 0);
    expect_val("rstovr_fault", F_FAULT, 0);
    expect_val("rstovr_urn", F_URN, 1);
    tick("rstovr", 0);
    reset = 0; ovr_req = 0; ovr_val = 0;
    expect_val("post_rst_ovr", F_OVR, 0);
    tick("post_rst", 0);

    // Transition beats timeout on the last watchdog cycle
    go_state2();
    csr_state = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick("race_wait", 2);
    csr_state = CSR_DONE; pspot_state = PSPOT_CFG_DONE;
    expect_val("race_fault", F_FAULT, 0);
    tick("race", 3);

    // External channel override in RST_WAIT
    do_reset();
    ovr_req = 5'b00100; ovr_val = 5'b00100;
    expect_val("ovr2_chan", F_CHAN, 5'b00100);
    expect_val("ovr2_act", F_OVR, 5'b00100);
    tick("ovr2", 0);
    ovr_req = 0; ovr_val = 0; fsm_chan = 5'b11000;
    expect_val("ovr2_fsm_hi", F_CHAN, 5'b11100);
    tick("ovr2_hi", 0);
    fsm_chan = 5'b00000;
    expect_val("ovr2_fsm_lo", F_CHAN, 5'b00100);
    tick("ovr2_lo", 0);
    ovr_req = 5'b00100; ovr_val = 5'b00000; fsm_chan = 5'b00111;
    expect_val("ovr2_recap", F_CHAN, 5'b00000);
    tick("ovr2_recap", 0);
    ovr_req = 0; fsm_chan = 0;

    // Gated channel overrides around INACTIVE/ACTIVE
    go_state6();
    ovr_req = 5'b00011; ovr_val = 5'b00011;
    expect_val("gate_inact_chan", F_CHAN, 0);
    expect_val("gate_inact_act", F_OVR, 5'b00011);
    tick("gate_inact", 6);
    ovr_req = 0; ovr_val = 0; sgclk_state = SG_STOPPED; ena_rise = 1;
    expect_val("gate_act_chan", F_CHAN, 5'b00011);
    tick("gate_act", 7);
    ena_rise = 0; ovr_req = 5'b00001; ovr_val = 5'b00000;
    expect_val("gate_ch0_off", F_CHAN, 5'b00010);
    tick("gate_ch0", 7);
    ovr_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
